// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Requester indices
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    // Default memory read latency in cycles
    localparam int unsigned MEM_LAT_DEFAULT = 2;

    // Latency counter width: holds MEM_LAT-1 with one bit of headroom
    function automatic int unsigned cnt_width(input int unsigned lat);
        return $clog2(lat) + 1;
    endfunction

endpackage

// File: rtl/arb2_pick.sv
// Combinational two-way request picker.
// rr_mode_i=1: under contention the port not served last wins.
// rr_mode_i=0: port 0 (CPU) always wins contention.
module arb2_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    input  logic       rr_mode_i,
    output logic       win_o,
    output logic       valid_o
);

    // Winner selection from the request vector and last-served pointer
    always_comb begin
        valid_o = |req_i;
        win_o   = PORT_CPU;
        if (req_i == 2'b11) begin
            win_o = rr_mode_i ? ~last_i : PORT_CPU;
        end else if (req_i[1]) begin
            win_o = PORT_LDR;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory sequencer/arbiter for the CPU datapath (port 0) and the
// loader/debug port (port 1). One access at a time: IDLE -> ACCESS -> RESP.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN for 2-way round-robin
// arbitration; otherwise port 0 has fixed priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 13,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned MEM_LAT = MEM_LAT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned      CNT_W    = cnt_width(MEM_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    state_e            state_q, state_d;
    logic              win_q, win_d;
    logic              we_q, we_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              busy_q, busy_d;

    logic              pick_win;
    logic              pick_valid;
    logic              last_ptr;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam logic RR_MODE = 1'b1;

    logic last_q, last_d;

    // Last-served pointer follows every grant
    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && pick_valid) begin
            last_d = pick_win;
        end
    end

    // Pointer register; reset to loader so the CPU wins the first contention
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= PORT_LDR;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_ptr = last_q;
`else
    localparam logic RR_MODE = 1'b0;

    assign last_ptr = PORT_LDR;
`endif

    arb2_pick u_pick (
        .req_i     ({req1, req0}),
        .last_i    (last_ptr),
        .rr_mode_i (RR_MODE),
        .win_o     (pick_win),
        .valid_o   (pick_valid)
    );

    // Next-state and registered-output decode
    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d  = ACCESS;
                    win_d    = pick_win;
                    cnt_d    = CNT_LOAD;
                    gnt0_d   = (pick_win == PORT_CPU);
                    gnt1_d   = (pick_win == PORT_LDR);
                    mem_en_d = 1'b1;
                    if (pick_win == PORT_CPU) begin
                        we_d        = we0;
                        mem_we_d    = we0;
                        mem_addr_d  = addr0;
                        mem_wdata_d = wdata0;
                    end else begin
                        we_d        = we1;
                        mem_we_d    = we1;
                        mem_addr_d  = addr1;
                        mem_wdata_d = wdata1;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    done0_d = (win_q == PORT_CPU);
                    done1_d = (win_q == PORT_LDR);
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            win_q       <= PORT_CPU;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign rdata     = rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-schedule model plus directed tests.
// Honours MEM_ARB_ROUND_ROBIN_EN the same way as the design.
module tb_mem_port_arbiter;

    localparam int LAT = 2;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [12:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1;
    logic        gnt0, gnt1, done0, done1;
    logic [7:0]  rdata;
    logic        mem_en, mem_we;
    logic [12:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        busy;

    // second instance, MEM_LAT=1
    logic        b_req0;
    logic        b_gnt0, b_gnt1, b_done0, b_done1;
    logic [7:0]  b_rdata;
    logic        b_mem_en, b_mem_we;
    logic [12:0] b_mem_addr;
    logic [7:0]  b_mem_wdata, b_mem_rdata;
    logic        b_busy;

    logic [7:0]  mem     [0:8191];
    logic [7:0]  ref_mem [0:8191];

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(13), .DATA_W(8), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(13), .DATA_W(8), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .req0(b_req0), .req1(1'b0), .we0(1'b0), .we1(1'b0),
        .addr0(13'h005), .addr1(13'h000), .wdata0(8'h00), .wdata1(8'h00),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .done0(b_done0), .done1(b_done1),
        .rdata(b_rdata), .mem_en(b_mem_en), .mem_we(b_mem_we),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory: asynchronous read of the held address, write on enabled edge
    assign mem_rdata   = mem[mem_addr];
    assign b_mem_rdata = mem[b_mem_addr];
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- schedule model ----------------
    // Accepting at edge a: gnt/mem_en after edge a, done after edge a+LAT,
    // busy after edges a..a+LAT, next acceptance possible at edge a+LAT+2.
    int          m_e, m_acc, m_free;
    bit          m_have, m_last, m_win, m_we;
    logic [12:0] m_addr;
    logic [7:0]  m_wdata, m_rd, m_rdata;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_e = 0; m_free = 0; m_have = 0; m_last = 1'b1;
            m_addr = '0; m_wdata = '0; m_rdata = '0;
        end else begin
            m_e++;
            if (m_have && m_e == m_acc + LAT && !m_we) m_rdata = m_rd;
            if (m_e >= m_free && (req0 || req1)) begin
                if (req0 && req1) m_win = RR ? !m_last : 1'b0;
                else              m_win = req1;
                m_last  = m_win;
                m_acc   = m_e;
                m_free  = m_e + LAT + 2;
                m_have  = 1'b1;
                m_we    = m_win ? we1 : we0;
                m_addr  = m_win ? addr1 : addr0;
                m_wdata = m_win ? wdata1 : wdata0;
                if (m_we) ref_mem[m_addr] = m_wdata;
                else      m_rd = ref_mem[m_addr];
            end
        end
    end

    task automatic compare();
        bit g, d, bz;
        g  = m_have && (m_e == m_acc);
        d  = m_have && (m_e == m_acc + LAT);
        bz = m_have && (m_e >= m_acc) && (m_e <= m_acc + LAT);
        chk("gnt0",      gnt0,      g && !m_win);
        chk("gnt1",      gnt1,      g && m_win);
        chk("done0",     done0,     d && !m_win);
        chk("done1",     done1,     d && m_win);
        chk("mem_en",    mem_en,    g);
        chk("mem_we",    mem_we,    g && m_we);
        chk("mem_addr",  mem_addr,  m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("rdata",     rdata,     m_rdata);
        chk("busy",      busy,      bz);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            compare();
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic run_txn(input bit port, input bit we, input logic [12:0] a,
                           input logic [7:0] wd, output logic [7:0] rd,
                           output int wecnt, output int bcnt, output int kg, output int kd);
        rd = '0; wecnt = 0; bcnt = 0; kg = -1; kd = -1;
        if (!port) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd; end
        else       begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd; end
        for (int k = 1; k <= 20 && kd < 0; k++) begin
            @(negedge clk);
            if (mem_we) wecnt++;
            if (busy) bcnt++;
            if (!port && gnt0) begin kg = k; req0 = 1'b0; end
            if (port && gnt1)  begin kg = k; req1 = 1'b0; end
            if ((!port && done0) || (port && done1)) begin kd = k; rd = rdata; end
        end
        chk("txn_done_seen", kd > 0, 1'b1);
        req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin : stim
        logic [7:0] rd;
        int wc, bc, kg, kd, cnt, g0c, g1c;
        bit ok;
        int gk[$];
        int gp[$];
        int exp_port[4];

        for (int unsigned i = 0; i < 8192; i++) begin
            mem[i]     = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        mem[5] = 8'hA7; ref_mem[5] = 8'hA7;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        b_req0 = 0;
        rst = 1'b1;
        #1 rst = 1'b0;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_outputs", {gnt0, gnt1, done0, done1, mem_en, mem_we, busy}, '0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_rdata", rdata, '0);
        rst = 1'b1;
        @(negedge clk);

        // single read of 0x005
        run_txn(1'b0, 1'b0, 13'h005, 8'h00, rd, wc, bc, kg, kd);
        chk("t1_gnt_cycle", kg, 1);
        chk("t1_done_cycle", kd, 3);
        chk("t1_rdata", rd, 8'hA7);
        chk("t1_busy_cycles", bc, 3);
        @(negedge clk);
        chk("t1_idle_after", busy, 1'b0);

        // loader write then CPU read back
        run_txn(1'b1, 1'b1, 13'h1FF, 8'h3C, rd, wc, bc, kg, kd);
        chk("t2_write_gnt_cycle", kg, 1);
        chk("t2_write_mem_we_cycles", wc, 1);
        chk("t2_write_done_cycle", kd, 3);
        chk("t2_mem_contents", mem[13'h1FF], 8'h3C);
        run_txn(1'b0, 1'b0, 13'h1FF, 8'h00, rd, wc, bc, kg, kd);
        chk("t2_read_back", rd, 8'h3C);
        chk("t2_read_mem_we_cycles", wc, 0);

        // contention, starting from a fresh reset pointer
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 13'h010;
        req1 = 1'b1; we1 = 1'b0; addr1 = 13'h020;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin gk.push_back(k); gp.push_back(gnt1 ? 1 : 0); end
        end
        req0 = 1'b0; req1 = 1'b0;
        if (RR) begin exp_port[0] = 0; exp_port[1] = 1; exp_port[2] = 0; exp_port[3] = 1; end
        else    begin exp_port[0] = 0; exp_port[1] = 0; exp_port[2] = 0; exp_port[3] = 0; end
        chk("t3_grant_count", gk.size(), 4);
        for (int i = 0; i < 4 && i < gk.size(); i++) begin
            chk($sformatf("t3_grant%0d_port", i), gp[i], exp_port[i]);
            chk($sformatf("t3_grant%0d_cycle", i), gk[i], 1 + 4 * i);
        end
        ok = 1'b0;
        for (int k = 0; k < 10 && !ok; k++) begin
            @(negedge clk);
            ok = !busy;
        end
        chk("t3_drain_idle", ok, 1'b1);

        // reset during the first ACCESS cycle of a read
        req0 = 1'b1; we0 = 1'b0; addr0 = 13'h0AB;
        @(negedge clk);
        chk("t4_gnt0_before_rst", gnt0, 1'b1);
        rst = 1'b0; req0 = 1'b0;
        #1;
        chk("t4_async_flags", {gnt0, gnt1, done0, done1, mem_en, mem_we, busy}, '0);
        chk("t4_async_mem_addr", mem_addr, '0);
        chk("t4_async_rdata", rdata, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            cnt += int'(done0) + int'(done1) + int'(busy);
        end
        chk("t4_no_done_after_rst", cnt, 0);
        run_txn(1'b0, 1'b0, 13'h0AB, 8'h00, rd, wc, bc, kg, kd);
        chk("t4_new_read_cycle", kd, 3);
        chk("t4_new_read_data", rd, 8'hF1);

        // request arriving during RESP
        req0 = 1'b1; we0 = 1'b0; addr0 = 13'h033;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (gnt0) req0 = 1'b0;
            ok = done0;
        end
        chk("t5_done0_seen", ok, 1'b1);
        chk("t5_rdata0", rdata, 8'h69);
        req1 = 1'b1; we1 = 1'b0; addr1 = 13'h044;
        @(negedge clk);
        chk("t5_no_gnt1_in_idle", gnt1, 1'b0);
        @(negedge clk);
        chk("t5_gnt1_two_later", gnt1, 1'b1);
        req1 = 1'b0;
        g1c = int'(gnt1); g0c = 0; ok = 1'b0;
        for (int k = 0; k < 10 && !ok; k++) begin
            @(negedge clk);
            g1c += int'(gnt1); g0c += int'(gnt0);
            ok = done1;
        end
        chk("t5_done1_seen", ok, 1'b1);
        chk("t5_rdata1", rdata, 8'h1E);
        chk("t5_gnt1_count", g1c, 1);
        chk("t5_gnt0_count", g0c, 0);

        // MEM_LAT=1 instance
        @(negedge clk);
        b_req0 = 1'b1;
        @(negedge clk);
        chk("lat1_gnt0", {b_gnt0, b_mem_en, b_done0}, 3'b110);
        b_req0 = 1'b0;
        @(negedge clk);
        chk("lat1_done0", {b_done0, b_busy}, 2'b11);
        chk("lat1_rdata", b_rdata, 8'hA7);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            cnt += int'(b_done0) + int'(b_busy) + int'(b_gnt0) + int'(b_done1);
        end
        chk("lat1_quiet_after", cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter for the CPU's single-port data/instruction memory. It shares the memory between two requesters: port 0 is the multicycle CPU datapath (fetch, operand read, result write), and port 1 is the loader/debug port used to preload programs and inspect memory. It serialises their requests, drives the memory for a fixed access latency, and returns a one-cycle completion strobe with read data to the winning port.

## Interface
Parameters:
- ADDR_W, 13: memory address width (8-bit IR field concatenated with the 5-bit DI field).
- DATA_W, 8: memory word width.
- MEM_LAT, 2: memory read latency in cycles. Must be ≥1.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset; the block is in reset while rst==0.
- req0, req1  in  1  access request from port 0 (CPU) and port 1 (loader).
- we0, we1  in  1  1 = write, 0 = read; held with req.
- addr0, addr1  in  ADDR_W  access address; held with req.
- wdata0, wdata1  in  DATA_W  write data; held with req.
- gnt0, gnt1  out  1  one-cycle pulse: request accepted and captured.
- done0, done1  out  1  one-cycle pulse: access complete.
- rdata  out  DATA_W  read data, valid while done0 or done1 is high for a read.
- mem_en, mem_we  out  1  memory enable and write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE:**
  - If req0 or req1 is high at the clock edge: pick a winner; latch its we, addr and wdata into internal registers; go to ACCESS.
  - If neither request is high: stay in IDLE.
- **ACCESS:**
  - First cycle: assert gnt of the winner, mem_en=1, and mem_we=latched we. Drive mem_addr and mem_wdata from the latches. Load the counter with MEM_LAT−1.
  - Later cycles: mem_en=0 and mem_we=0. The counter decrements each cycle.
  - When the counter is 0: capture mem_rdata into the rdata register (reads only) and go to RESP.
- **RESP:** done of the winner is 1 for one cycle; go to IDLE.
- Writes take the same path and latency as reads; rdata is not updated on a write.
- Requester rule: hold req, we, addr and wdata stable until gnt.
  - req may drop after gnt.
  - req still high in the cycle after done is treated as a new request.
- A req deasserted before gnt is silently withdrawn; there is no error.
- Counter width is $clog2(MEM_LAT)+1. The counter saturates at 0 and never wraps.
- Reset values: state=IDLE, all gnt, done, mem_en and mem_we = 0, mem_addr=0, mem_wdata=0, rdata=0, busy=0, round-robin pointer = 1 (port 0 wins the first contention).
- Reset mid-access: the transaction is dropped and no done is issued. A write already issued to the memory may have landed; the requester must reissue.

## Timing
- req sampled high at edge N → gnt and mem_en high during cycle N+1 → done high during cycle N+1+MEM_LAT.
- rdata is valid in the same cycle as done.
- Back-to-back issue rate: one access per MEM_LAT+2 cycles, because IDLE is always visited between accesses.
- Simultaneous req0 and req1 in IDLE: one winner per the arbitration policy. The loser keeps req high and is served on the next IDLE pass.
- A request arriving during ACCESS or RESP waits. No request is lost provided req is held.
- All outputs are registered, with no combinational path from req to gnt.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: 2-way round-robin.
  - Under contention, the port not served last wins.
  - The pointer updates on every grant.
- MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority, port 0 (CPU) always wins contention.
  - The loader is served only when req0 is low in IDLE.
  - The pointer logic is absent.

## Structure
- Package mem_arb_pkg contains:
  - the state enum (IDLE, ACCESS, RESP);
  - port index constants PORT_CPU=0 and PORT_LDR=1;
  - a default MEM_LAT constant.
- Sub-module arb2_pick: combinational 2-way picker. Inputs: req vector, last-served pointer, mode. Output: winner index and a valid flag. It is instantiated once in IDLE decode.

## Test plan
- Reset, then req0=1 read, addr0=0x005, memory holds 0xA7, MEM_LAT=2 → gnt0 pulse at cycle 1, mem_en at cycle 1, done0 at cycle 3 with rdata=0xA7; busy high cycles 1–3.
- req1 write, addr1=0x1FF, wdata1=0x3C, then req0 read of 0x1FF → mem_we=1 only in the write's first ACCESS cycle; the later read returns 0x3C.
- req0 and req1 both held high continuously:
  - with MEM_ARB_ROUND_ROBIN_EN, grants alternate 0,1,0,1, one every 4 cycles;
  - without it, only gnt0 fires.
- rst driven low during the ACCESS cycle of a read → all outputs 0 immediately. After rst rises, no done is issued and state is IDLE; a new req0 completes normally.
- Request arriving during RESP: req1 rises while done0 is high → gnt1 two cycles later, with no lost or duplicated grant.
- MEM_LAT=1 build: req0 read → done0 exactly 2 cycles after the sampling edge; the counter never wraps.
